// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Round-robin two-port arbiter/sequencer for the data memory.
//               Owns the memory stall (chip-enable) and holds the load op and
//               address through the read-response cycle, because the memory
//               formats load data from the op/address seen in that cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
   parameter int AW = 11,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          m0_req,
   input  logic [2:0]    m0_op,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   output logic          m0_gnt,
   output logic          m0_rvalid,
   output logic [DW-1:0] m0_rdata,
   input  logic          m1_req,
   input  logic [2:0]    m1_op,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   output logic          m1_gnt,
   output logic          m1_rvalid,
   output logic [DW-1:0] m1_rdata,
   output logic          mem_stall,
   output logic [2:0]    mem_op_code,
   output logic [AW-1:0] mem_rwaddr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RESP = 1'b1;

   // An idle memory sees a load-type op so that nothing can be written.
   localparam logic [2:0] C_IDLE_OP = 3'b111;

   logic [0:0]    r_state;
   logic [0:0]    w_state_next;
   logic          r_last;      // port granted most recently
   logic          r_id;        // owner of the outstanding load
   logic [2:0]    r_op;
   logic [AW-1:0] r_addr;
   logic          r_rvalid0;
   logic          r_rvalid1;
   logic [DW-1:0] r_rdata0;
   logic [DW-1:0] r_rdata1;

   logic          w_any_req;
   logic          w_pick1;     // 1 = port 1 wins this cycle
   logic          w_win_load;
   logic          w_grant;     // a grant is issued this cycle

   // Round-robin winner selection: on a tie, the port that was not last wins.
   always_comb begin
      w_any_req  = m0_req | m1_req;
      w_pick1    = m1_req & (~m0_req | ~r_last);
      w_win_load = w_pick1 ? m1_op[2] : m0_op[2];
      w_grant    = ~rst & (r_state == S_IDLE) & w_any_req;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next state: a granted load spends one cycle in RESP; stores stay in IDLE.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (w_grant && w_win_load) w_state_next = S_RESP;
         S_RESP:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // Outputs: grants and the memory port; reset forces the idle values.
   always_comb begin
      m0_gnt      = 1'b0;
      m1_gnt      = 1'b0;
      mem_stall   = 1'b1;
      mem_op_code = C_IDLE_OP;
      mem_rwaddr  = '0;
      mem_wdata   = '0;
      if (!rst) begin
         case (r_state)
            S_IDLE: begin
               if (w_any_req) begin
                  mem_stall = 1'b0;
                  if (w_pick1) begin
                     m1_gnt      = 1'b1;
                     mem_op_code = m1_op;
                     mem_rwaddr  = m1_addr;
                     mem_wdata   = m1_wdata;
                  end else begin
                     m0_gnt      = 1'b1;
                     mem_op_code = m0_op;
                     mem_rwaddr  = m0_addr;
                     mem_wdata   = m0_wdata;
                  end
               end
            end
            S_RESP: begin
               mem_op_code = r_op;
               mem_rwaddr  = r_addr;
            end
            default: ;
         endcase
      end
   end

   // Arbitration pointer and load context, captured on each grant.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_last <= 1'b1;
         r_id   <= 1'b0;
         r_op   <= C_IDLE_OP;
         r_addr <= '0;
      end else if (w_grant) begin
         r_last <= w_pick1;
         if (w_win_load) begin
            r_id   <= w_pick1;
            r_op   <= w_pick1 ? m1_op : m0_op;
            r_addr <= w_pick1 ? m1_addr : m0_addr;
         end
      end
   end

   // Read response: capture formatted data into the owning port in RESP.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rvalid0 <= 1'b0;
         r_rvalid1 <= 1'b0;
         r_rdata0  <= '0;
         r_rdata1  <= '0;
      end else begin
         r_rvalid0 <= (r_state == S_RESP) && !r_id;
         r_rvalid1 <= (r_state == S_RESP) &&  r_id;
         if ((r_state == S_RESP) && !r_id) r_rdata0 <= mem_rdata;
         if ((r_state == S_RESP) &&  r_id) r_rdata1 <= mem_rdata;
      end
   end

   assign m0_rvalid = r_rvalid0;
   assign m1_rvalid = r_rvalid1;
   assign m0_rdata  = r_rdata0;
   assign m1_rdata  = r_rdata1;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter with a small
//               behavioural model of the two-bank data memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

   localparam int AW = 11;
   localparam int DW = 32;

   // Op codes of the memory model: bit 2 = load, bits 1:0 = size.
   localparam logic [2:0] OP_SB  = 3'b000;
   localparam logic [2:0] OP_SH  = 3'b001;
   localparam logic [2:0] OP_SW  = 3'b010;
   localparam logic [2:0] OP_LB  = 3'b100;
   localparam logic [2:0] OP_LH  = 3'b101;
   localparam logic [2:0] OP_LW  = 3'b110;
   localparam logic [2:0] OP_IDL = 3'b111;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          m0_req = 1'b0, m1_req = 1'b0;
   logic [2:0]    m0_op = OP_IDL, m1_op = OP_IDL;
   logic [AW-1:0] m0_addr = '0, m1_addr = '0;
   logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
   logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
   logic [DW-1:0] m0_rdata, m1_rdata;
   logic          mem_stall;
   logic [2:0]    mem_op_code;
   logic [AW-1:0] mem_rwaddr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   int checks = 0;
   int errors = 0;

   mem_arbiter #(.AW(AW), .DW(DW)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_op(m0_op), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_op(m1_op), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .mem_stall(mem_stall), .mem_op_code(mem_op_code), .mem_rwaddr(mem_rwaddr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // ---------------- memory model ----------------
   logic [31:0] mem_arr [512];
   logic [31:0] rword;

   always @(posedge clk) begin
      if (!mem_stall) begin
         if (!mem_op_code[2]) begin
            case (mem_op_code[1:0])
               2'b00: mem_arr[mem_rwaddr[10:2]][8*mem_rwaddr[1:0] +: 8] <= mem_wdata[7:0];
               2'b01: mem_arr[mem_rwaddr[10:2]][16*mem_rwaddr[1] +: 16] <= mem_wdata[15:0];
               default: mem_arr[mem_rwaddr[10:2]] <= mem_wdata;
            endcase
         end else begin
            rword <= mem_arr[mem_rwaddr[10:2]];
         end
      end
   end

   // Load formatting uses the op/address presented in the response cycle.
   always_comb begin
      logic [7:0]  b;
      logic [15:0] h;
      b = rword[8*mem_rwaddr[1:0] +: 8];
      h = rword[16*mem_rwaddr[1] +: 16];
      case (mem_op_code)
         OP_LB:   mem_rdata = {{24{b[7]}}, b};
         OP_LH:   mem_rdata = {{16{h[15]}}, h};
         OP_LW:   mem_rdata = rword;
         default: mem_rdata = {24'h0, b};
      endcase
   end

   // ---------------- stimulus helpers (no checking) ----------------
   task automatic next_cycle();
      @(negedge clk);
   endtask

   task automatic clear_reqs();
      m0_req = 1'b0; m1_req = 1'b0;
      m0_op = OP_IDL; m1_op = OP_IDL;
      m0_addr = '0; m1_addr = '0;
      m0_wdata = '0; m1_wdata = '0;
   endtask

   task automatic do_reset();
      next_cycle();
      clear_reqs();
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      next_cycle();
      rst = 1'b1;
      m0_req = 1'b1; m0_op = OP_SW; m0_addr = 11'h7FC; m0_wdata = 32'h12345678;
      m1_req = 1'b1; m1_op = OP_LW; m1_addr = 11'h004;
      #1;
      checks++;
      if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin
         errors++; $display("FAIL reset_gnt: got %b%b want 00", m0_gnt, m1_gnt);
      end
      checks++;
      if (mem_stall !== 1'b1 || mem_op_code !== OP_IDL || mem_rwaddr !== '0 || mem_wdata !== '0) begin
         errors++;
         $display("FAIL reset_mem: got stall=%b op=%b addr=%h wdata=%h want 1 111 000 00000000",
                  mem_stall, mem_op_code, mem_rwaddr, mem_wdata);
      end
      next_cycle();
      clear_reqs();
      rst = 1'b0;
      #1;
      checks++;
      if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0 || m0_rdata !== '0 || m1_rdata !== '0) begin
         errors++;
         $display("FAIL reset_resp: got rv=%b%b rd0=%h rd1=%h want 00 0 0",
                  m0_rvalid, m1_rvalid, m0_rdata, m1_rdata);
      end
   endtask

   task automatic test_store_load();
      next_cycle();
      m0_req = 1'b1; m0_op = OP_SW; m0_addr = 11'h010; m0_wdata = 32'hDEADBEEF;
      #1;
      checks++;
      if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0 || mem_stall !== 1'b0) begin
         errors++; $display("FAIL store_gnt: got gnt=%b%b stall=%b want 10 0", m0_gnt, m1_gnt, mem_stall);
      end
      checks++;
      if (mem_op_code !== OP_SW || mem_rwaddr !== 11'h010 || mem_wdata !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL store_drive: got op=%b addr=%h wdata=%h want 010 010 deadbeef",
                  mem_op_code, mem_rwaddr, mem_wdata);
      end
      next_cycle();
      clear_reqs();
      m1_req = 1'b1; m1_op = OP_LW; m1_addr = 11'h010;
      #1;
      checks++;
      if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0) begin
         errors++; $display("FAIL load_gnt: got gnt=%b%b want 01", m0_gnt, m1_gnt);
      end
      next_cycle();
      clear_reqs();
      #1;
      checks++;
      if (mem_stall !== 1'b1 || m1_rvalid !== 1'b0 || m1_gnt !== 1'b0) begin
         errors++; $display("FAIL load_resp: got stall=%b rvalid=%b gnt=%b want 1 0 0", mem_stall, m1_rvalid, m1_gnt);
      end
      next_cycle();
      #1;
      checks++;
      if (m1_rvalid !== 1'b1 || m1_rdata !== 32'hDEADBEEF || m0_rvalid !== 1'b0) begin
         errors++;
         $display("FAIL load_data: got rv1=%b rd1=%h rv0=%b want 1 deadbeef 0", m1_rvalid, m1_rdata, m0_rvalid);
      end
      next_cycle();
      #1;
      checks++;
      if (m1_rvalid !== 1'b0) begin
         errors++; $display("FAIL load_pulse: got rv1=%b want 0", m1_rvalid);
      end
   endtask

   task automatic test_bank_hold();
      next_cycle();
      m1_req = 1'b1; m1_op = OP_SW; m1_addr = 11'h404; m1_wdata = 32'h000080FF;
      #1;
      checks++;
      if (m1_gnt !== 1'b1) begin
         errors++; $display("FAIL bank_store_gnt: got %b want 1", m1_gnt);
      end
      next_cycle();
      clear_reqs();
      m0_req = 1'b1; m0_op = OP_LB; m0_addr = 11'h405;
      #1;
      checks++;
      if (m0_gnt !== 1'b1 || mem_stall !== 1'b0) begin
         errors++; $display("FAIL bank_load_gnt: got gnt=%b stall=%b want 1 0", m0_gnt, mem_stall);
      end
      next_cycle();
      clear_reqs();
      #1;
      checks++;
      if (mem_rwaddr !== 11'h405 || mem_stall !== 1'b1 || mem_op_code !== OP_LB) begin
         errors++;
         $display("FAIL bank_hold: got addr=%h stall=%b op=%b want 405 1 100", mem_rwaddr, mem_stall, mem_op_code);
      end
      next_cycle();
      #1;
      checks++;
      if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hFFFFFF80) begin
         errors++; $display("FAIL bank_data: got rv0=%b rd0=%h want 1 ffffff80", m0_rvalid, m0_rdata);
      end
      checks++;
      if (m1_rvalid !== 1'b0 || m1_rdata !== 32'hDEADBEEF) begin
         errors++; $display("FAIL bank_other_hold: got rv1=%b rd1=%h want 0 deadbeef", m1_rvalid, m1_rdata);
      end
   endtask

   task automatic test_contention();
      logic eg0, eg1, ev0, ev1;
      do_reset();
      m0_req = 1'b1; m0_op = OP_LW; m0_addr = 11'h010;
      m1_req = 1'b1; m1_op = OP_LW; m1_addr = 11'h404;
      for (int c = 0; c < 7; c++) begin
         #1;
         eg0 = (c == 0) || (c == 4);
         eg1 = (c == 2) || (c == 6);
         ev0 = (c == 2) || (c == 6);
         ev1 = (c == 4);
         checks++;
         if (m0_gnt !== eg0 || m1_gnt !== eg1) begin
            errors++; $display("FAIL contend_gnt c=%0d: got %b%b want %b%b", c, m0_gnt, m1_gnt, eg0, eg1);
         end
         checks++;
         if (m0_rvalid !== ev0 || m1_rvalid !== ev1) begin
            errors++; $display("FAIL contend_rvalid c=%0d: got %b%b want %b%b", c, m0_rvalid, m1_rvalid, ev0, ev1);
         end
         if (ev0) begin
            checks++;
            if (m0_rdata !== 32'hDEADBEEF) begin
               errors++; $display("FAIL contend_rd0 c=%0d: got %h want deadbeef", c, m0_rdata);
            end
         end
         if (ev1) begin
            checks++;
            if (m1_rdata !== 32'h000080FF) begin
               errors++; $display("FAIL contend_rd1 c=%0d: got %h want 000080ff", c, m1_rdata);
            end
         end
         next_cycle();
      end
      clear_reqs();
      next_cycle();
      next_cycle();
   endtask

   task automatic test_back_to_back();
      logic eg0;
      do_reset();
      m0_req = 1'b1; m0_op = OP_SW; m0_addr = 11'h020; m0_wdata = 32'h11111111;
      m1_req = 1'b1; m1_op = OP_SW; m1_addr = 11'h024; m1_wdata = 32'h22222222;
      for (int c = 0; c < 3; c++) begin
         #1;
         eg0 = (c != 1);
         checks++;
         if (m0_gnt !== eg0 || m1_gnt !== !eg0 || mem_stall !== 1'b0) begin
            errors++;
            $display("FAIL b2b_store c=%0d: got gnt=%b%b stall=%b want %b%b 0", c, m0_gnt, m1_gnt, mem_stall, eg0, !eg0);
         end
         next_cycle();
      end
      clear_reqs();
      m0_req = 1'b1; m0_op = OP_LW; m0_addr = 11'h024;
      next_cycle();
      clear_reqs();
      next_cycle();
      #1;
      checks++;
      if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h22222222) begin
         errors++; $display("FAIL b2b_readback: got rv0=%b rd0=%h want 1 22222222", m0_rvalid, m0_rdata);
      end
   endtask

   task automatic test_reset_resp();
      do_reset();
      m1_req = 1'b1; m1_op = OP_LW; m1_addr = 11'h010;
      #1;
      checks++;
      if (m1_gnt !== 1'b1) begin
         errors++; $display("FAIL rresp_gnt: got %b want 1", m1_gnt);
      end
      next_cycle();
      clear_reqs();
      rst = 1'b1;
      #1;
      checks++;
      if (mem_stall !== 1'b1 || mem_op_code !== OP_IDL || mem_rwaddr !== '0) begin
         errors++;
         $display("FAIL rresp_mem: got stall=%b op=%b addr=%h want 1 111 000", mem_stall, mem_op_code, mem_rwaddr);
      end
      next_cycle();
      rst = 1'b0;
      #1;
      checks++;
      if (m1_rvalid !== 1'b0 || m0_rvalid !== 1'b0 || m1_rdata !== '0 || m0_rdata !== '0) begin
         errors++;
         $display("FAIL rresp_suppress: got rv=%b%b rd0=%h rd1=%h want 00 0 0", m0_rvalid, m1_rvalid, m0_rdata, m1_rdata);
      end
      m0_req = 1'b1; m0_op = OP_LW; m0_addr = 11'h010;
      m1_req = 1'b1; m1_op = OP_LW; m1_addr = 11'h010;
      #1;
      checks++;
      if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
         errors++; $display("FAIL rresp_tie: got gnt=%b%b want 10", m0_gnt, m1_gnt);
      end
      next_cycle();
      clear_reqs();
      next_cycle();
      next_cycle();
   endtask

   task automatic test_idle();
      clear_reqs();
      for (int c = 0; c < 10; c++) begin
         next_cycle();
         #1;
         checks++;
         if (mem_stall !== 1'b1 || mem_op_code !== OP_IDL || m0_gnt !== 1'b0 || m1_gnt !== 1'b0
             || m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL idle c=%0d: got stall=%b op=%b gnt=%b%b rv=%b%b want 1 111 00 00",
                     c, mem_stall, mem_op_code, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid);
         end
      end
   endtask

   initial begin
      test_reset();
      test_store_load();
      test_bank_hold();
      test_contention();
      test_back_to_back();
      test_reset_resp();
      test_idle();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
